// File: rtl/t_word_unpacker.sv
// Unpacks SRAM words into a valid/ready stream of {t, v, f} elements, slot 0 first.
// Define T_WORD_UNPACKER_PREFETCH_EN for a two-word buffer that keeps the stream gap-free.
module t_word_unpacker #(
  parameter int SRAM_WORD  = 128,
  parameter int VEF_BIT    = 15,
  parameter int T_SIZE_LOG = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [T_SIZE_LOG-1:0] i_T_size,
  output logic                  o_sram_request,
  input  logic                  i_request_valid,
  input  logic [SRAM_WORD-1:0]  i_request_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [1:0]            o_t,
  output logic [VEF_BIT-1:0]    o_v,
  output logic [VEF_BIT-1:0]    o_f,
  output logic                  o_t_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int ELEM_W = 2 + 2*VEF_BIT;
  localparam int SLOTS  = SRAM_WORD / ELEM_W;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [T_SIZE_LOG-1:0] remain_q, remain_d;
  logic [T_SIZE_LOG-1:0] wtf_q, wtf_d;
  logic [SRAM_WORD-1:0]  head_q, head_d;
  logic                  head_vld_q, head_vld_d;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
  logic [SRAM_WORD-1:0]  nxt_q, nxt_d;
  logic                  nxt_vld_q, nxt_vld_d;
`endif
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  req_q, req_d;
  logic                  inflight_q;
  logic                  valid_q, valid_d;
  logic [1:0]            t_q, t_d;
  logic [VEF_BIT-1:0]    v_q, v_d;
  logic [VEF_BIT-1:0]    f_q, f_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  hs, last_hs, free, wr;
  logic [1:0]            occ;
  logic [T_SIZE_LOG:0]   words_total;
  logic [ELEM_W-1:0]     elem;

  always_comb begin
    hs      = valid_q && i_ready;
    last_hs = hs && (remain_q == T_SIZE_LOG'(1));
    free    = hs && (last_hs || (slot_q == SLOT_W'(SLOTS - 1)));
    wr      = (state_q == S_RUN) && inflight_q && i_request_valid;

    words_total = ({1'b0, i_T_size} + (T_SIZE_LOG+1)'(SLOTS - 1)) / (T_SIZE_LOG+1)'(SLOTS);

    state_d    = state_q;
    remain_d   = remain_q;
    wtf_d      = wtf_q;
    head_d     = head_q;
    head_vld_d = head_vld_q;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
    nxt_d      = nxt_q;
    nxt_vld_d  = nxt_vld_q;
`endif
    slot_d     = slot_q;
    req_d      = 1'b0;
    occ        = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_T_size == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            remain_d = i_T_size;
            wtf_d    = T_SIZE_LOG'(words_total - 1'b1);
            req_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          remain_d = remain_q - T_SIZE_LOG'(1);
          slot_d   = slot_q + SLOT_W'(1);
        end
        if (free) begin
          slot_d     = '0;
          head_vld_d = 1'b0;
        end
`ifdef T_WORD_UNPACKER_PREFETCH_EN
        if (free && nxt_vld_q) begin
          head_d     = nxt_q;
          head_vld_d = 1'b1;
          nxt_vld_d  = 1'b0;
        end
        if (wr) begin
          if (!head_vld_d) begin
            head_d     = i_request_data;
            head_vld_d = 1'b1;
          end else begin
            nxt_d     = i_request_data;
            nxt_vld_d = 1'b1;
          end
        end
        occ = {1'b0, head_vld_d} + {1'b0, nxt_vld_d};
`else
        if (wr) begin
          head_d     = i_request_data;
          head_vld_d = 1'b1;
        end
        occ = {1'b0, head_vld_d};
`endif
        // Occupancy is taken after this cycle's free/write, so a freed entry is reusable at once.
        if (last_hs) begin
          state_d = S_DONE;
        end else if ((wtf_q != '0) && ((occ + {1'b0, req_q}) < 2'(CAP))) begin
          req_d = 1'b1;
          wtf_d = wtf_q - T_SIZE_LOG'(1);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        head_vld_d = 1'b0;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
        nxt_vld_d  = 1'b0;
`endif
        slot_d     = '0;
        remain_d   = '0;
        wtf_d      = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded from the next buffer state so data appears the cycle after arrival.
    elem    = head_d[int'(slot_d) * ELEM_W +: ELEM_W];
    valid_d = (state_d == S_RUN) && head_vld_d && (remain_d != '0);
    t_d     = valid_d ? elem[ELEM_W-1 -: 2] : '0;
    v_d     = valid_d ? elem[2*VEF_BIT-1 -: VEF_BIT] : '0;
    f_d     = valid_d ? elem[VEF_BIT-1:0] : '0;
    last_d  = valid_d && (remain_d == T_SIZE_LOG'(1));
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      wtf_q      <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
      nxt_q      <= '0;
      nxt_vld_q  <= 1'b0;
`endif
      slot_q     <= '0;
      req_q      <= 1'b0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      t_q        <= '0;
      v_q        <= '0;
      f_q        <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      wtf_q      <= wtf_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
      nxt_q      <= nxt_d;
      nxt_vld_q  <= nxt_vld_d;
`endif
      slot_q     <= slot_d;
      req_q      <= req_d;
      inflight_q <= req_q;
      valid_q    <= valid_d;
      t_q        <= t_d;
      v_q        <= v_d;
      f_q        <= f_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_sram_request = req_q;
  assign o_valid        = valid_q;
  assign o_t            = t_q;
  assign o_v            = v_q;
  assign o_f            = f_q;
  assign o_t_last       = last_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_t_word_unpacker.sv
// Scoreboard bench for t_word_unpacker: SRAM responder, random words, expected element queue.
`timescale 1ns/1ps
module tb_t_word_unpacker;
  localparam int SRAM_WORD  = 128;
  localparam int VEF_BIT    = 15;
  localparam int T_SIZE_LOG = 16;
  localparam int ELEM_W     = 2 + 2*VEF_BIT;
  localparam int SLOTS      = SRAM_WORD / ELEM_W;
`ifdef T_WORD_UNPACKER_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  i_start = 1'b0;
  logic [T_SIZE_LOG-1:0] i_T_size = '0;
  logic                  o_sram_request;
  logic                  i_request_valid = 1'b0;
  logic [SRAM_WORD-1:0]  i_request_data = '0;
  logic                  o_valid;
  logic                  i_ready = 1'b0;
  logic [1:0]            o_t;
  logic [VEF_BIT-1:0]    o_v;
  logic [VEF_BIT-1:0]    o_f;
  logic                  o_t_last;
  logic                  o_busy;
  logic                  o_done;

  always #5 clk = ~clk;

  t_word_unpacker #(
    .SRAM_WORD (SRAM_WORD),
    .VEF_BIT   (VEF_BIT),
    .T_SIZE_LOG(T_SIZE_LOG)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_T_size       (i_T_size),
    .o_sram_request (o_sram_request),
    .i_request_valid(i_request_valid),
    .i_request_data (i_request_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_t            (o_t),
    .o_v            (o_v),
    .o_f            (o_f),
    .o_t_last       (o_t_last),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  typedef struct {
    logic [1:0]         t;
    logic [VEF_BIT-1:0] v;
    logic [VEF_BIT-1:0] f;
    logic               last;
    int                 cyc;
  } exp_t;

  exp_t                 exp_q[$];
  logic [SRAM_WORD-1:0] sram_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_mode = 0;
  bit timing_chk = 0;
  int hs_cnt = 0, req_cnt = 0, done_cnt = 0;
  int done_cyc = 0, first_req_cyc = 0, last_hs_cyc = 0;
  logic req_s = 1'b0;
  logic spurious = 1'b0;

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc - start_cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM responder: data one cycle after each request pulse.
  always @(negedge clk) req_s <= o_sram_request;
  always @(posedge clk) begin
    #1;
    if (req_s) begin
      i_request_valid = 1'b1;
      i_request_data  = (sram_q.size() > 0) ? sram_q.pop_front() : '0;
    end else begin
      i_request_valid = spurious;
      i_request_data  = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  always @(posedge clk) begin
    int k;
    #1;
    k = cyc - start_cyc - 3;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = (k >= 0) && ((k % 4 == 0) || (k % 4 == 3));
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake and checks hold behaviour during stalls.
  logic               stall_prev = 1'b0;
  logic [1:0]         pt;
  logic [VEF_BIT-1:0] pv, pf;
  logic               pl;
  exp_t               me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_sram_request) begin
        if (req_cnt == 0) first_req_cyc = cyc;
        req_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", o_busy, 0);
      end
      if (stall_prev) begin
        check("hold_valid", o_valid, 1);
        check("hold_t", o_t, pt);
        check("hold_v", o_v, pv);
        check("hold_f", o_f, pf);
        check("hold_last", o_t_last, pl);
      end
      if (o_valid) check("busy_while_valid", o_busy, 1);
      if (o_valid && i_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_element: got t=%0d v=%0h f=%0h, required none", o_t, o_v, o_f);
        end else begin
          me = exp_q.pop_front();
          check("elem_t", o_t, me.t);
          check("elem_v", o_v, me.v);
          check("elem_f", o_f, me.f);
          check("elem_last", o_t_last, me.last);
          if (timing_chk) check("elem_cycle", cyc - start_cyc, me.cyc);
        end
      end
      stall_prev = o_valid && !i_ready;
      pt = o_t; pv = o_v; pf = o_f; pl = o_t_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // kind: 0 random, 1 t = 0,1,2,3,3,2,1,0, 2 slot 0 forced to v=7FFF f=0001.
  task automatic run_pass(input int T, input int mode, input int kind, input bit restart, input int abort_at);
    int nw, idx;
    logic [SRAM_WORD-1:0] w;
    logic [ELEM_W-1:0] el;
    exp_t e;
    nw = (T + SLOTS - 1) / SLOTS;
    for (int wi = 0; wi < nw; wi++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < SLOTS; s++) begin
        idx = wi * SLOTS + s;
        el = w[s*ELEM_W +: ELEM_W];
        if (kind == 1) el[ELEM_W-1 -: 2] = 2'((idx < 4) ? idx : 7 - idx);
        if (kind == 2 && idx == 0) el[2*VEF_BIT-1:0] = {15'h7FFF, 15'h0001};
        w[s*ELEM_W +: ELEM_W] = el;
        if (idx < T) begin
          e.t    = el[ELEM_W-1 -: 2];
          e.v    = el[2*VEF_BIT-1 -: VEF_BIT];
          e.f    = el[VEF_BIT-1:0];
          e.last = (idx == T - 1);
          e.cyc  = 3 + idx + ((PF != 0) ? 0 : 2 * (idx / SLOTS));
          exp_q.push_back(e);
        end
      end
      sram_q.push_back(w);
    end
    hs_cnt = 0; req_cnt = 0; done_cnt = 0;
    ready_mode = mode;
    timing_chk = (mode == 0);
    @(posedge clk); #1;
    i_T_size  = T[T_SIZE_LOG-1:0];
    i_start   = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 1; k < 400 && done_cnt == 0; k++) begin
      if (abort_at > 0 && k == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", {o_valid, o_sram_request, o_busy, o_done, o_t_last, o_t, o_v, o_f}, 0);
        exp_q.delete();
        sram_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        return;
      end
      i_start  = restart && (k == 4);
      i_T_size = (restart && k == 4) ? T_SIZE_LOG'(T + 3) : T_SIZE_LOG'(T);
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    if (done_cnt == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no o_done, required one within 400 cycles (T=%0d)", T);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("handshakes", hs_cnt, T);
    check("requests", req_cnt, nw);
    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_valid", o_valid, 0);
    check("idle_busy", o_busy, 0);
    if (T > 0) begin
      check("first_req_cycle", first_req_cyc - start_cyc, 1);
      check("done_after_last", done_cyc - last_hs_cyc, 1);
    end else begin
      check("zero_done_cycle", done_cyc - start_cyc, 1);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_valid, o_sram_request, o_busy, o_done, o_t_last, o_t, o_v, o_f}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass(8, 0, 1, 1'b0, 0);
    run_pass(6, 0, 0, 1'b0, 0);
    run_pass(0, 0, 0, 1'b0, 0);
    run_pass(5, 1, 2, 1'b0, 0);
    run_pass(8, 0, 0, 1'b0, 5);
    run_pass(4, 0, 0, 1'b0, 0);
    run_pass(8, 0, 0, 1'b1, 0);

    @(negedge clk) spurious = 1'b1;
    @(negedge clk) spurious = 1'b0;
    run_pass(5, 0, 0, 1'b0, 0);

    for (int r = 0; r < 8; r++) run_pass(int'($urandom_range(1, 13)), 2, 0, 1'b0, 0);
    run_pass(12, 0, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
